// File: rtl/sap_ctrl_pkg.sv
// sap_ctrl_pkg: opcodes, T-state encodings and control-word layout shared by the SAP-U sequencer
package sap_ctrl_pkg;
  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;
  typedef enum logic [2:0] {
    T1     = 3'd0,
    T2     = 3'd1,
    T3     = 3'd2,
    T4     = 3'd3,
    T5     = 3'd4,
    T6     = 3'd5,
    T_ILL  = 3'd6,
    T_HALT = 3'd7
  } t_state_e;
  localparam int CW_W  = 12;
  localparam int CW_CP = 11;
  localparam int CW_EP = 10;
  localparam int CW_LM = 9;
  localparam int CW_CE = 8;
  localparam int CW_LI = 7;
  localparam int CW_EI = 6;
  localparam int CW_LA = 5;
  localparam int CW_EA = 4;
  localparam int CW_SU = 3;
  localparam int CW_EU = 2;
  localparam int CW_LB = 1;
  localparam int CW_LO = 0;
  typedef logic [CW_W-1:0] ctrl_word_t;
endpackage

// File: rtl/sap_ring_counter.sv
// sap_ring_counter: T1..T6 ring with early return, HALT trap and recovery from the unused code
module sap_ring_counter
  import sap_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic       early_end,
  input  logic       halt_req,
  output logic [2:0] t_state
);
  t_state_e state_q, state_d;
  always_ff @(posedge clk or posedge reset)
    if (reset) state_q <= T1;
    else state_q <= state_d;
  // HALT ignores run; the illegal code self-recovers even while stalled
  always_comb begin
    state_d = state_q;
    case (state_q)
      T_HALT: state_d = T_HALT;
      T_ILL:  state_d = T1;
      default: state_d = !run ? state_q :
                         halt_req ? T_HALT :
                         (early_end || state_q == T6) ? T1 :
                         t_state_e'(state_q + 3'd1);
    endcase
  end
  assign t_state = state_q;
endmodule

// File: rtl/sap_control_sequencer.sv
// sap_control_sequencer: SAP-U opcode decoder driving every bus load/enable line per T-state
module sap_control_sequencer
  import sap_ctrl_pkg::*;
#(
  parameter bit EARLY_END = 1'b0,
  parameter int OP_W      = 4
)
(
  input  logic            clk,
  input  logic            reset,
  input  logic            run,
  input  logic [OP_W-1:0] opcode,
  output logic            pc_inc,
  output logic            pc_out,
  output logic            mar_load,
  output logic            ram_out,
  output logic            ir_load,
  output logic            ir_out,
  output logic            a_load,
  output logic            a_out,
  output logic            alu_sub,
  output logic            alu_out,
  output logic            b_load,
  output logic            out_load,
  output logic            halted,
  output logic [2:0]      t_state
);
  logic is_lda, is_add, is_sub, is_out, is_hlt, is_mem, is_alu, is_nop;
  logic early_end, halt_req;
  ctrl_word_t cw, ctrl;
  assign is_lda = opcode == OP_W'(OP_LDA);
  assign is_add = opcode == OP_W'(OP_ADD);
  assign is_sub = opcode == OP_W'(OP_SUB);
  assign is_out = opcode == OP_W'(OP_OUT);
  assign is_hlt = opcode == OP_W'(OP_HLT);
  assign is_alu = is_add || is_sub;
  assign is_mem = is_lda || is_alu;
  assign is_nop = !(is_mem || is_out || is_hlt);
  assign halt_req = t_state == T4 && is_hlt;
  assign halted = t_state == T_HALT;
  sap_ring_counter u_ring (
    .clk       (clk),
    .reset     (reset),
    .run       (run),
    .early_end (early_end),
    .halt_req  (halt_req),
    .t_state   (t_state)
  );
  // fetch ignores opcode entirely; execute decodes only in T4..T6
  always_comb begin
    cw = '0;
    early_end = 1'b0;
    case (t_state)
      T1: begin
        cw[CW_EP] = 1'b1;
        cw[CW_LM] = 1'b1;
      end
      T2: cw[CW_CP] = 1'b1;
      T3: begin
        cw[CW_CE] = 1'b1;
        cw[CW_LI] = 1'b1;
      end
      T4: begin
        cw[CW_EI] = is_mem;
        cw[CW_LM] = is_mem;
        cw[CW_EA] = is_out;
        cw[CW_LO] = is_out;
        early_end = EARLY_END && (is_out || is_nop);
      end
      T5: begin
        cw[CW_CE] = is_mem;
        cw[CW_LA] = is_lda;
        cw[CW_LB] = is_alu;
        early_end = EARLY_END && is_lda;
      end
      T6: begin
        cw[CW_EU] = is_alu;
        cw[CW_LA] = is_alu;
        cw[CW_SU] = is_sub;
      end
      default: ;
    endcase
  end
  assign ctrl = (reset || halted) ? '0 : cw;
  assign pc_inc   = ctrl[CW_CP];
  assign pc_out   = ctrl[CW_EP];
  assign mar_load = ctrl[CW_LM];
  assign ram_out  = ctrl[CW_CE];
  assign ir_load  = ctrl[CW_LI];
  assign ir_out   = ctrl[CW_EI];
  assign a_load   = ctrl[CW_LA];
  assign a_out    = ctrl[CW_EA];
  assign alu_sub  = ctrl[CW_SU];
  assign alu_out  = ctrl[CW_EU];
  assign b_load   = ctrl[CW_LB];
  assign out_load = ctrl[CW_LO];
  // only one storage element may drive the shared bus per cycle
  a_bus_onehot: assert property (@(posedge clk) disable iff (reset)
    $onehot0({pc_out, ram_out, ir_out, a_out, alu_out}));
endmodule
